// File: rtl/key_event_queue.sv
// key_event_queue: merges key press pulses into a FIFO of key events,
// with an optional auto-repeat generator enabled by macro KEY_REPEAT_EN.
//
// Ports:
//   clk, rst            single clock, async active-high reset
//   key_pulse[15:0]     one-clk press pulses, index = key number
//   key_out[15:0]       debounced key levels, active-low (repeat only)
//   evt_valid/ready     head-of-queue handshake
//   evt_code, evt_rpt   head event key number / auto-repeat flag
//   evt_count           number of queued events (0..DEPTH)
//   ovf, ovf_clr        sticky duplicate-press flag and its clear
module key_event_queue #(
    parameter int DEPTH       = 8,
    parameter int REPEAT_DLY  = 6000000,
    parameter int REPEAT_RATE = 1200000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [15:0]            key_pulse,
    input  logic [15:0]            key_out,
    output logic                   evt_valid,
    input  logic                   evt_ready,
    output logic [3:0]             evt_code,
    output logic                   evt_rpt,
    output logic [$clog2(DEPTH):0] evt_count,
    output logic                   ovf,
    input  logic                   ovf_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [15:0]   pending;
    logic [15:0]   req;
    logic [15:0]   push_hot;
    logic [3:0]    sel;
    logic          found;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [4:0]    mem [DEPTH];
    logic [4:0]    head;
    logic [4:0]    push_data;
    logic          pop;
    logic          can_push;
    logic          push_fresh;
    logic          push_rpt;
    logic          push;
    logic          rpt_req;
    logic [3:0]    rpt_key;

    assign req = pending | key_pulse;

    // lowest-index requesting key wins
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if (req[i]) begin
                sel   = 4'(i);
                found = 1'b1;
            end
        end
    end

    assign evt_valid  = (evt_count != '0);
    assign pop        = evt_valid & evt_ready;
    // a pop on the same edge frees the slot a full FIFO needs
    assign can_push   = (evt_count != FULL) | pop;
    assign push_fresh = found & can_push;
    // repeats yield to any pending fresh press
    assign push_rpt   = rpt_req & ~found & can_push;
    assign push       = push_fresh | push_rpt;
    assign push_hot   = push_fresh ? (16'd1 << sel) : 16'd0;
    assign push_data  = push_fresh ? {1'b0, sel} : {1'b1, rpt_key};

    assign head     = mem[rd_ptr];
    assign evt_code = head[3:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            evt_count <= '0;
            ovf       <= 1'b0;
        end else begin
            pending <= req & ~push_hot;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push & ~pop)
                evt_count <= evt_count + 1'b1;
            else if (pop & ~push)
                evt_count <= evt_count - 1'b1;
            // duplicate press on an already-pending key is merged
            if (|(key_pulse & pending & ~push_hot))
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

`ifdef KEY_REPEAT_EN
    localparam int RMAX = (REPEAT_DLY > REPEAT_RATE) ?
                          REPEAT_DLY : REPEAT_RATE;
    localparam int CW   = $clog2(RMAX + 1) + 1;

    logic          rep_on;
    logic          rep_hold;
    logic [CW-1:0] rep_cnt;
    logic          held;

    assign evt_rpt = head[4];
    assign held    = ~key_out[rpt_key];
    // a request fires at terminal count or stays held until served
    assign rpt_req = rep_on & held & (rep_hold | (rep_cnt == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_on   <= 1'b0;
            rep_hold <= 1'b0;
            rep_cnt  <= '0;
            rpt_key  <= '0;
        end else if (push_fresh) begin
            rpt_key  <= sel;
            rep_on   <= 1'b1;
            rep_hold <= 1'b0;
            rep_cnt  <= CW'(REPEAT_DLY - 1);
        end else if (rep_on & ~held) begin
            rep_on   <= 1'b0;
            rep_hold <= 1'b0;
        end else if (rep_on) begin
            rep_hold <= rpt_req & ~push_rpt;
            if (rep_cnt == '0)
                rep_cnt <= CW'(REPEAT_RATE - 1);
            else
                rep_cnt <= rep_cnt - 1'b1;
        end
    end
`else
    logic unused_in;

    assign evt_rpt   = 1'b0;
    assign rpt_req   = 1'b0;
    assign rpt_key   = '0;
    assign unused_in = head[4] ^ (^key_out);
`endif
endmodule

// File: doc/key_event_queue.md
KEY_EVENT_QUEUE -- requirements
Module: key_event_queue

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries; power of two, 2..64.
REQ-002 Parameter REPEAT_DLY, default 6000000, clocks a key is held before the first repeat event (0.5 s at 12 MHz).
REQ-003 Parameter REPEAT_RATE, default 1200000, clocks between subsequent repeat events (0.1 s at 12 MHz).
REQ-004 clk  input  1  system clock; the block has a single clock domain.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 key_pulse  input  16  one-clk active-high press pulses from the matrix scanner, index = key number.
REQ-007 key_out  input  16  debounced key levels, active-low (0 = held).
REQ-008 evt_valid  output  1  head-of-queue event available.
REQ-009 evt_ready  input  1  consumer accepts the head event.
REQ-010 evt_code  output  4  key number of the head event.
REQ-011 evt_rpt  output  1  head event is an auto-repeat (1) or a fresh press (0).
REQ-012 evt_count  output  clog2(DEPTH)+1  number of queued events.
REQ-013 ovf  output  1  sticky overflow flag.
REQ-014 ovf_clr  input  1  synchronous clear of ovf.

Function
REQ-015 A 16-bit pending mask shall latch every key_pulse bit at the clk edge where it is 1.
REQ-016 Each edge, the lowest-index set bit of (pending | key_pulse) shall be pushed as {rpt=0, code} when the FIFO is not full, and its pending bit shall clear; all other bits shall stay pending.
REQ-017 Latency: a pulse on an empty, idle block gives evt_valid=1 with the matching evt_code in the cycle following the sampling edge.
REQ-018 Pop occurs on any edge with evt_valid & evt_ready; evt_ready while empty is ignored.
REQ-019 Push and pop on the same edge when full shall both succeed; evt_count shall remain unchanged.
REQ-020 When the FIFO is full with no pop, pushes stall and pending bits are retained; no data is lost.
REQ-021 ovf shall set when a key_pulse bit arrives for a key whose pending bit is already set and is not pushed on that edge; the duplicate is merged (dropped).
REQ-022 ovf_clr clears ovf; a set event on the same edge takes priority over the clear.
REQ-023 evt_code and evt_rpt are driven from FIFO storage and are undefined-but-stable while evt_valid=0; they shall hold stable while evt_valid=1 and evt_ready=0.
REQ-024 Read and write pointers are clog2(DEPTH) bits, wrap modulo DEPTH, and evt_count is in the range 0..DEPTH.

Reset
REQ-025 With rst=1, the following shall clear asynchronously: pending=0, FIFO pointers=0, evt_count=0, evt_valid=0, ovf=0, and repeat state idle.
REQ-026 Reset asserted mid-operation discards all queued and pending events; the first edge after release behaves as from power-up.

Configuration
REQ-027 With macro KEY_REPEAT_EN defined, the block tracks the most recently pushed fresh-press code K.
REQ-028 With KEY_REPEAT_EN defined, while key_out[K]=0 a counter runs: a repeat request raises after REPEAT_DLY clocks, then every REPEAT_RATE clocks.
REQ-029 With KEY_REPEAT_EN defined, key_out[K]=1 shall return the repeat counter to idle and drop any unserved request.
REQ-030 With KEY_REPEAT_EN defined, a repeat request pushes {rpt=1, K} only on edges with no pending press and FIFO not full, and is held otherwise.
REQ-031 With KEY_REPEAT_EN defined, a new fresh press pushed for a different key retargets K and restarts the counter.
REQ-032 Without KEY_REPEAT_EN, key_out is ignored, no repeat logic is built, and evt_rpt is tied to 0.

Verification
REQ-033 Single press: key_pulse=16'h0020 for 1 clk, evt_ready=0 -> next cycle evt_valid=1, evt_code=5, evt_rpt=0, evt_count=1.
REQ-034 Simultaneous press: key_pulse=16'h8101 for 1 clk, evt_ready=1 -> evt_code sequence 0, 8, 15 on three consecutive cycles, then evt_valid=0.
REQ-035 Full and overflow (DEPTH=8): 8 pulses on keys 0..7 with evt_ready=0 -> evt_count=8; then pulse key 9 twice -> pending[9]=1, ovf=1; one pop -> key 9 enqueued, evt_count=8.
REQ-036 Wrap-around: 20 pulses on keys 0..15,0..3 with evt_ready=1 continuously -> output order identical to input order, no ovf.
REQ-037 Repeat (KEY_REPEAT_EN, REPEAT_DLY=10, REPEAT_RATE=4): press key 3 and hold key_out[3]=0 for 30 clks -> events {3,0}, then {3,1} at +10, +14, +18, +22, +26; release -> no further events.
REQ-038 Reset mid-stream: 5 events queued, rst pulsed high for 1 clk -> evt_valid=0 and evt_count=0 immediately; ovf=0.
